// File: rtl/id_hazard_pkg.sv
// id_hazard_pkg: shared constants and types for the decode-stage scoreboard.
//   NUM_REGS    architectural register count (x0 is never tracked)
//   REG_ADDR_W  register index width
//   SB_CNT_W    width of one per-register pending-write counter
//   SB_CNT_MAX  saturation value of a pending-write counter
package id_hazard_pkg;

    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SB_CNT_W   = 2;
    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;

    // One decoded source operand.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] idx;
        logic                  used;
    } src_t;

endpackage

// File: rtl/id_hazard_sb_entry.sv
// sb_entry: one saturating pending-write counter of the scoreboard.
//   clk, rst        rising-edge clock, synchronous active-high reset
//   inc             an issued instruction will write this register
//   dec_wb          writeback retires a write to this register
//   dec_kill        a flush cancels a write to this register
//   cnt             current count
//   nonzero, full   cnt != 0, cnt == SB_CNT_MAX
//   underflow       this cycle's net update would go below zero (combinational)
module sb_entry
    import id_hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec_wb,
    input  logic                dec_kill,
    output logic [SB_CNT_W-1:0] cnt,
    output logic                nonzero,
    output logic                full,
    output logic                underflow
);

    logic [SB_CNT_W:0]   up;
    logic [1:0]          dn;
    logic [SB_CNT_W:0]   diff;
    logic [SB_CNT_W-1:0] cnt_nxt;

    // Net update +inc -wb -kill in one step; clamp both ends.
    always_comb begin
        up        = {1'b0, cnt} + {{SB_CNT_W{1'b0}}, inc};
        dn        = {1'b0, dec_wb} + {1'b0, dec_kill};
        underflow = (up < {1'b0, dn});
        diff      = underflow ? '0 : (up - {1'b0, dn});
        cnt_nxt   = (diff > {1'b0, SB_CNT_MAX}) ? SB_CNT_MAX : diff[SB_CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    assign nonzero = (cnt != '0);
    assign full    = (cnt == SB_CNT_MAX);

endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: register scoreboard and issue gate for the decode stage.
//   clk, outside_reset           clock, synchronous active-high reset
//   id_valid, rs*_id, rs*_used,
//   rd_id, regwrite_id           decoded instruction
//   ex_ready                     execute accepts an instruction
//   regwrite_wb, rd_wb           writeback retire (rd_wb=0: retire only)
//   kill_vld, kill_rd            cancelled in-flight write
//   stall_id, issue              decode hold / instruction leaves decode
//   inflight, busy               in-flight count, inflight != 0
//   err_underflow                sticky: a retire or kill hit a zero counter
module id_hazard_ctrl
    import id_hazard_pkg::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int WB_BYPASS    = 1
) (
    input  logic                  clk,
    input  logic                  outside_reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd_id,
    input  logic                  regwrite_id,
    input  logic                  ex_ready,
    input  logic                  regwrite_wb,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  kill_vld,
    input  logic [REG_ADDR_W-1:0] kill_rd,
    output logic                  stall_id,
    output logic                  issue,
    output logic [2:0]            inflight,
    output logic                  busy,
    output logic                  err_underflow
);

    localparam logic [2:0] MAX_I = 3'(MAX_INFLIGHT);

    logic [NUM_REGS-1:0][SB_CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]               nonzero, full, uf;

    // x0 is hardwired: never pending, never full, never underflows.
    assign cnt[0]     = '0;
    assign nonzero[0] = 1'b0;
    assign full[0]    = 1'b0;
    assign uf[0]      = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_sb
        sb_entry u_sb (
            .clk      (clk),
            .rst      (outside_reset),
            .inc      (issue & regwrite_id & (rd_id == REG_ADDR_W'(g))),
            .dec_wb   (regwrite_wb & (rd_wb == REG_ADDR_W'(g))),
            .dec_kill (kill_vld & (kill_rd == REG_ADDR_W'(g))),
            .cnt      (cnt[g]),
            .nonzero  (nonzero[g]),
            .full     (full[g]),
            .underflow(uf[g])
        );
    end

    src_t [1:0] src;
    logic [1:0] hz;
    assign src[0] = '{idx: rs1_id, used: rs1_used};
    assign src[1] = '{idx: rs2_id, used: rs2_used};

    // A source whose only pending write retires this cycle is readable when
    // the register file writes before it reads. Kills never satisfy a read.
    for (genvar s = 0; s < 2; s++) begin : g_src
        logic byp;
        assign byp   = (WB_BYPASS != 0) && (cnt[src[s].idx] == SB_CNT_W'(1))
                       && regwrite_wb && (rd_wb == src[s].idx);
        assign hz[s] = src[s].used && nonzero[src[s].idx] && !byp;
    end

    // Budget is checked on the registered count, so a same-cycle retire
    // does not open a slot.
    assign stall_id = id_valid & ((|hz) | (inflight == MAX_I) | (regwrite_id & full[rd_id]));
    assign issue    = id_valid & ~stall_id & ex_ready;
    assign busy     = (inflight != 3'd0);

    logic [3:0] inf_up, inf_diff;
    logic [1:0] inf_dn;
    logic       inf_uf;

    always_comb begin
        inf_up   = {1'b0, inflight} + {3'b0, issue};
        inf_dn   = {1'b0, regwrite_wb} + {1'b0, kill_vld};
        inf_uf   = (inf_up < {2'b0, inf_dn});
        inf_diff = inf_uf ? 4'd0 : (inf_up - {2'b0, inf_dn});
    end

    always_ff @(posedge clk) begin
        if (outside_reset) begin
            inflight      <= 3'd0;
            err_underflow <= 1'b0;
        end else begin
            inflight <= inf_diff[2:0];
            if (inf_uf || (|uf)) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_hazard_ctrl.sv
module tb_id_hazard_ctrl;

    localparam int MAXI = 3;
    localparam int BYP  = 1;

    logic       clk = 1'b0;
    logic       outside_reset;
    logic       id_valid, rs1_used, rs2_used, regwrite_id, ex_ready;
    logic [4:0] rs1_id, rs2_id, rd_id, rd_wb, kill_rd;
    logic       regwrite_wb, kill_vld;
    logic       stall_id, issue, busy, err_underflow;
    logic [2:0] inflight;

    id_hazard_ctrl #(.MAX_INFLIGHT(MAXI), .WB_BYPASS(BYP)) dut (
        .clk(clk), .outside_reset(outside_reset),
        .id_valid(id_valid), .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_id(rd_id), .regwrite_id(regwrite_id), .ex_ready(ex_ready),
        .regwrite_wb(regwrite_wb), .rd_wb(rd_wb),
        .kill_vld(kill_vld), .kill_rd(kill_rd),
        .stall_id(stall_id), .issue(issue), .inflight(inflight),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: pending-write count per register, in-flight count.
    int m_cnt [32];
    int m_inf;
    bit m_err;
    bit model_ok = 1'b0;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hz(input logic [4:0] rs, input logic used);
        bit byp;
        byp = (BYP != 0) && (m_cnt[rs] == 1) && regwrite_wb && (rd_wb == rs);
        return used && (rs != 0) && (m_cnt[rs] != 0) && !byp;
    endfunction

    function automatic bit exp_stall();
        return id_valid && (hz(rs1_id, rs1_used) || hz(rs2_id, rs2_used) ||
               (m_inf == MAXI) || (regwrite_id && rd_id != 0 && m_cnt[rd_id] == 3));
    endfunction

    function automatic bit exp_issue();
        return id_valid && !exp_stall() && ex_ready;
    endfunction

    always @(posedge clk) begin : model_upd
        int v;
        bit iss;
        if (outside_reset) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_inf    = 0;
            m_err    = 1'b0;
            model_ok = 1'b1;
        end else if (model_ok) begin
            iss = exp_issue();
            for (int r = 1; r < 32; r++) begin
                v = m_cnt[r];
                if (iss && regwrite_id && rd_id == r) v++;
                if (regwrite_wb && rd_wb == r) v--;
                if (kill_vld && kill_rd == r) v--;
                if (v < 0) begin v = 0; m_err = 1'b1; end
                if (v > 3) v = 3;
                m_cnt[r] = v;
            end
            v = m_inf + int'(iss) - int'(regwrite_wb) - int'(kill_vld);
            if (v < 0) begin v = 0; m_err = 1'b1; end
            m_inf = v;
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("stall_id", stall_id, exp_stall());
            chk("issue", issue, exp_issue());
            chk("inflight", inflight, m_inf);
            chk("busy", busy, m_inf != 0);
            chk("err_underflow", err_underflow, m_err);
        end
    end

    task automatic idle();
        id_valid = 0; rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0;
        rd_id = 0; regwrite_id = 0; ex_ready = 0;
        regwrite_wb = 0; rd_wb = 0; kill_vld = 0; kill_rd = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ins(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic w);
        id_valid = 1; rs1_id = r1; rs1_used = u1; rs2_id = r2; rs2_used = u2;
        rd_id = rd; regwrite_id = w; ex_ready = 1;
    endtask

    initial begin
        int pend [$];
        idle();
        outside_reset = 1;
        cyc(); cyc();
        outside_reset = 0;

        // Reset state; issue follows id_valid & ex_ready.
        id_valid = 1; ex_ready = 1;
        #2;
        chk("rst_stall", stall_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_inflight", inflight, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_issue", issue, 1);
        idle();
        cyc();

        // RAW on x5 until its writeback arrives (bypassed same cycle).
        ins(0, 0, 0, 0, 5, 1); #2 chk("t1_issue_x5", issue, 1); cyc();
        ins(5, 1, 0, 0, 6, 1); #2 chk("t1_raw_stall", stall_id, 1); chk("t1_raw_noissue", issue, 0); cyc();
        #2 chk("t1_raw_stall2", stall_id, 1); cyc();
        regwrite_wb = 1; rd_wb = 5;
        #2 chk("t1_byp_stall", stall_id, 0); chk("t1_byp_issue", issue, 1); cyc();
        idle(); #2 chk("t1_inflight", inflight, 1);
        regwrite_wb = 1; rd_wb = 6; cyc();
        idle(); #2 chk("t1_drain", inflight, 0); chk("t1_busy", busy, 0);

        // In-flight budget.
        for (int i = 1; i <= 3; i++) begin ins(0, 0, 0, 0, 5'(i), 1); cyc(); end
        ins(0, 0, 0, 0, 0, 0); regwrite_wb = 1; rd_wb = 1;
        #2 chk("t2_inflight3", inflight, 3); chk("t2_budget_stall", stall_id, 1); cyc();
        regwrite_wb = 0;
        #2 chk("t2_after_wb_issue", issue, 1); cyc();
        idle(); regwrite_wb = 1; rd_wb = 2; cyc();
        rd_wb = 3; cyc();
        rd_wb = 0; cyc();
        idle(); #2 chk("t2_drain", inflight, 0);

        // x0 operands never stall; ex_ready low does not stall.
        ins(0, 1, 0, 1, 0, 1);
        #2 chk("t3_nostall", stall_id, 0); chk("t3_issue", issue, 1);
        ex_ready = 0;
        #1 chk("t3_exr_issue", issue, 0); chk("t3_exr_stall", stall_id, 0);
        ex_ready = 1; cyc();
        idle(); regwrite_wb = 1; rd_wb = 0; cyc();
        idle(); #2 chk("t3_drain", inflight, 0);

        // Issue and writeback to x7 in the same cycle.
        ins(0, 0, 0, 0, 7, 1); cyc();
        ins(0, 0, 0, 0, 7, 1); regwrite_wb = 1; rd_wb = 7;
        #2 chk("t4_issue", issue, 1); cyc();
        idle(); ins(7, 1, 0, 0, 0, 0);
        #2 chk("t4_still_pending", stall_id, 1); chk("t4_inflight", inflight, 1);
        idle(); regwrite_wb = 1; rd_wb = 7; cyc();
        idle(); #2 chk("t4_drain", inflight, 0);

        // Writeback and kill to x4 together.
        ins(0, 0, 0, 0, 4, 1); cyc();
        ins(0, 0, 0, 0, 4, 1); cyc();
        idle(); regwrite_wb = 1; rd_wb = 4; kill_vld = 1; kill_rd = 4;
        #2 chk("t5_inflight2", inflight, 2); cyc();
        idle(); #2 chk("t5_inflight0", inflight, 0); chk("t5_busy", busy, 0); chk("t5_noerr", err_underflow, 0);

        // Underflow on x9 is sticky until reset.
        regwrite_wb = 1; rd_wb = 9; cyc();
        idle(); #2 chk("t6_err", err_underflow, 1);
        cyc(); cyc(); cyc();
        #2 chk("t6_err_sticky", err_underflow, 1);
        outside_reset = 1; cyc();
        outside_reset = 0; #2 chk("t6_err_clr", err_underflow, 0);
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            idle();
            pend.delete();
            for (int r = 1; r < 32; r++) if (m_cnt[r] > 0) pend.push_back(r);
            id_valid    = ($urandom % 10) < 7;
            rs1_id      = 5'($urandom_range(0, 7));
            rs2_id      = 5'($urandom_range(0, 7));
            rs1_used    = 1'($urandom);
            rs2_used    = 1'($urandom);
            rd_id       = 5'($urandom_range(0, 7));
            regwrite_id = ($urandom % 4) != 0;
            ex_ready    = ($urandom % 5) != 0;
            if (m_inf > 0 && ($urandom % 3) == 0) begin
                regwrite_wb = 1;
                if (pend.size() > 0 && ($urandom % 4) != 0)
                    rd_wb = 5'(pend[$urandom_range(0, pend.size() - 1)]);
            end
            if (($urandom % 50) == 0) begin regwrite_wb = 1; rd_wb = 5'($urandom); end
            if (($urandom % 20) == 0) begin
                kill_vld = 1;
                kill_rd  = (pend.size() > 0) ? 5'(pend[$urandom_range(0, pend.size() - 1)])
                                             : 5'($urandom);
            end
            outside_reset = ($urandom % 500) == 0;
            cyc();
        end
        outside_reset = 0;
        idle();
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
